// File: rtl/shift_sequencer.sv
// Shared iterative shifter: two requesters arbitrated round-robin, one bit position per cycle,
// tagged result returned over a valid/ready handshake.
module shift_sequencer #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [1:0]   req0_op,
    input  logic [N-1:0] req0_data,
    input  logic [N-1:0] req0_amt,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [1:0]   req1_op,
    input  logic [N-1:0] req1_data,
    input  logic [N-1:0] req1_amt,
    output logic         res_valid,
    input  logic         res_ready,
    output logic [N-1:0] res_data,
    output logic         res_id,
    output logic         busy
);

    localparam int CW = $clog2(N + 1);
    localparam logic [N-1:0]  N_AMT = N[N-1:0];
    localparam logic [CW-1:0] N_CNT = N[CW-1:0];
    localparam logic [CW-1:0] ONE_C = {{(CW-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t        state_q;
    logic [1:0]    op_q;
    logic [N-1:0]  data_q;
    logic          id_q;
    logic [CW-1:0] rem_q;
    logic          last_q;
    logic          res_valid_q;
    logic          busy_q;

    logic          grant0_s;
    logic          grant1_s;
    logic [1:0]    sel_op_s;
    logic [N-1:0]  sel_data_s;
    logic [N-1:0]  sel_amt_s;
    logic [CW-1:0] count_s;

    function automatic logic [N-1:0] shift_step(input logic [1:0] op, input logic [N-1:0] d);
        logic [N-1:0] r;
        case (op)
            2'b00:   r = {d[N-2:0], 1'b0};
            2'b01:   r = {1'b0, d[N-1:1]};
            2'b10:   r = {d[N-1], d[N-1:1]};
            2'b11:   r = {d[0], d[N-1:1]};
            default: r = d;
        endcase
        return r;
    endfunction

    // Round-robin grant: a tie goes to the requester that was not served last.
    always_comb begin
        grant0_s = 1'b0;
        grant1_s = 1'b0;
        if (state_q == IDLE) begin
            if (req0_valid && req1_valid) begin
                grant0_s = last_q;
                grant1_s = ~last_q;
            end else begin
                grant0_s = req0_valid;
                grant1_s = req1_valid;
            end
        end else begin
            grant0_s = 1'b0;
            grant1_s = 1'b0;
        end
    end

    // Operand mux for the winner and its iteration count.
    always_comb begin
        if (grant1_s) begin
            sel_op_s   = req1_op;
            sel_data_s = req1_data;
            sel_amt_s  = req1_amt;
        end else begin
            sel_op_s   = req0_op;
            sel_data_s = req0_data;
            sel_amt_s  = req0_amt;
        end
        case (sel_op_s)
            2'b11:   count_s = CW'(sel_amt_s % N_AMT);
            default: count_s = (sel_amt_s >= N_AMT) ? N_CNT : CW'(sel_amt_s);
        endcase
    end

    // Sequencer FSM; the load step happens on the accept edge itself.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            op_q        <= 2'b00;
            data_q      <= '0;
            id_q        <= 1'b0;
            rem_q       <= '0;
            last_q      <= 1'b1;
            res_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant0_s || grant1_s) begin
                        op_q   <= sel_op_s;
                        data_q <= sel_data_s;
                        id_q   <= grant1_s;
                        last_q <= grant1_s;
                        busy_q <= 1'b1;
                        rem_q  <= count_s;
                        if (count_s == '0) begin
                            state_q     <= DONE;
                            res_valid_q <= 1'b1;
                        end else begin
                            state_q <= SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    data_q <= shift_step(op_q, data_q);
                    rem_q  <= rem_q - ONE_C;
                    if (rem_q == ONE_C) begin
                        state_q     <= DONE;
                        res_valid_q <= 1'b1;
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        state_q     <= IDLE;
                        res_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    res_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign req0_ready = grant0_s;
    assign req1_ready = grant1_s;
    assign res_valid  = res_valid_q;
    assign res_data   = data_q;
    assign res_id     = id_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Scoreboard bench for shift_sequencer: a cycle model predicts grants, latency and results.
module tb_shift_sequencer;

    localparam int N = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req0_valid, req1_valid;
    logic       req0_ready, req1_ready;
    logic [1:0] req0_op, req1_op;
    logic [3:0] req0_data, req1_data, req0_amt, req1_amt;
    logic       res_valid, res_ready, res_id, busy;
    logic [3:0] res_data;

    shift_sequencer #(.N(N)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_data(req0_data), .req0_amt(req0_amt),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_data(req1_data), .req1_amt(req1_amt),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_id(res_id), .busy(busy)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    typedef struct {
        logic       id;
        logic [3:0] data;
        int         due;
    } exp_t;

    exp_t sb[$];
    logic glog[$];
    int   acc_cnt[2];
    logic m_last = 1'b1;
    int   cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [3:0] ref_res(input logic [1:0] op, input logic [3:0] d, input logic [3:0] a);
        logic [7:0] dd;
        case (op)
            2'b00:   ref_res = (a >= 4'd4) ? 4'd0 : (d << a);
            2'b01:   ref_res = (a >= 4'd4) ? 4'd0 : (d >> a);
            2'b10:   ref_res = 4'($signed(d) >>> a);
            default: begin
                dd = {d, d} >> (a % 4'd4);
                ref_res = dd[3:0];
            end
        endcase
    endfunction

    function automatic int ref_lat(input logic [1:0] op, input logic [3:0] a);
        if (op == 2'b11) ref_lat = int'(a % 4'd4);
        else ref_lat = (a > 4'd4) ? 4 : int'(a);
    endfunction

    // Cycle model: sampled on the falling edge, predicts the DUT outputs for this cycle.
    initial begin
        logic idle, g0, g1, exp_rv, gid;
        logic [1:0] op;
        logic [3:0] d, a;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                sb.delete();
                m_last = 1'b1;
            end else begin
                idle   = (sb.size() == 0);
                g0     = idle && req0_valid && (!req1_valid || m_last);
                g1     = idle && req1_valid && (!req0_valid || !m_last);
                exp_rv = 1'b0;
                if (!idle) exp_rv = (cyc >= sb[0].due);
                check_eq("req0_ready", req0_ready, g0);
                check_eq("req1_ready", req1_ready, g1);
                check_eq("both_ready", req0_ready && req1_ready, 1'b0);
                check_eq("busy", busy, !idle);
                check_eq("res_valid", res_valid, exp_rv);
                if (exp_rv) begin
                    check_eq("res_data", res_data, sb[0].data);
                    check_eq("res_id", res_id, sb[0].id);
                    if (res_ready) void'(sb.pop_front());
                end
                if (g0 || g1) begin
                    gid = g1;
                    op  = gid ? req1_op : req0_op;
                    d   = gid ? req1_data : req0_data;
                    a   = gid ? req1_amt : req0_amt;
                    sb.push_back('{id: gid, data: ref_res(op, d, a), due: cyc + 1 + ref_lat(op, a)});
                    m_last = gid;
                    acc_cnt[gid]++;
                    glog.push_back(gid);
                end
            end
        end
    end

    task automatic drive(input int id, input logic [1:0] op, input logic [3:0] d, input logic [3:0] a);
        if (id == 0) begin
            req0_valid = 1'b1; req0_op = op; req0_data = d; req0_amt = a;
        end else begin
            req1_valid = 1'b1; req1_op = op; req1_data = d; req1_amt = a;
        end
    endtask

    task automatic send(input int id, input logic [1:0] op, input logic [3:0] d, input logic [3:0] a);
        int start, n;
        @(posedge clk); #2;
        drive(id, op, d, a);
        start = acc_cnt[id];
        n = 0;
        while (acc_cnt[id] == start && n < 50) begin
            @(posedge clk); #2;
            n++;
        end
        if (n >= 50) check_eq("accept_timeout", acc_cnt[id], start + 1);
        if (id == 0) req0_valid = 1'b0;
        else req1_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(posedge clk); #2;
            n++;
        end
        if (n >= 100) check_eq("idle_timeout", sb.size(), 0);
        @(posedge clk); #2;
    endtask

    initial begin
        int start, n;
        rst_n = 1'b0; res_ready = 1'b1;
        req0_valid = 1'b0; req0_op = 2'b00; req0_data = 4'd0; req0_amt = 4'd0;
        req1_valid = 1'b0; req1_op = 2'b00; req1_data = 4'd0; req1_amt = 4'd0;
        #1;
        check_eq("rst_res_valid", res_valid, 1'b0);
        check_eq("rst_res_data", res_data, 4'd0);
        check_eq("rst_res_id", res_id, 1'b0);
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_req0_ready", req0_ready, 1'b0);
        check_eq("rst_req1_ready", req1_ready, 1'b0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;

        // Both requesters held valid right after reset: strict alternation from req0.
        @(posedge clk); #2;
        drive(0, 2'b00, 4'b0011, 4'd1);
        drive(1, 2'b11, 4'b1001, 4'd2);
        start = glog.size();
        n = 0;
        while (glog.size() < start + 4 && n < 200) begin
            @(posedge clk); #2;
            n++;
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        check_eq("t4_grant_count", glog.size(), start + 4);
        for (int i = 0; i < 4; i++) check_eq("t4_grant_order", glog[start + i], i % 2);
        wait_idle();

        send(0, 2'b00, 4'b0011, 4'd2); wait_idle();
        send(1, 2'b10, 4'b1000, 4'd1); wait_idle();
        send(0, 2'b10, 4'b1000, 4'd7); wait_idle();
        send(1, 2'b01, 4'b1011, 4'd0); wait_idle();
        send(0, 2'b11, 4'b0001, 4'd5); wait_idle();
        send(1, 2'b11, 4'b0110, 4'd4); wait_idle();
        send(0, 2'b00, 4'b1111, 4'd9); wait_idle();
        send(1, 2'b11, 4'b1011, 4'd3); wait_idle();
        send(0, 2'b01, 4'b1101, 4'd4); wait_idle();

        // Consumer stalls in DONE; the model checks hold and stability every cycle.
        res_ready = 1'b0;
        send(0, 2'b01, 4'b1100, 4'd1);
        repeat (5) @(posedge clk);
        #2 res_ready = 1'b1;
        wait_idle();

        // Reset in the middle of a shift drops the operation.
        send(0, 2'b00, 4'b0001, 4'd3);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check_eq("t6_res_valid", res_valid, 1'b0);
        check_eq("t6_res_data", res_data, 4'd0);
        check_eq("t6_res_id", res_id, 1'b0);
        check_eq("t6_busy", busy, 1'b0);
        check_eq("t6_req0_ready", req0_ready, 1'b0);
        check_eq("t6_req1_ready", req1_ready, 1'b0);
        @(posedge clk); #2 rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #2;
        start = glog.size();
        drive(1, 2'b01, 4'b1000, 4'd1);
        drive(0, 2'b00, 4'b0101, 4'd1);
        n = 0;
        while (glog.size() == start && n < 50) begin
            @(posedge clk); #2;
            n++;
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        check_eq("t6_tie_count", glog.size(), start + 1);
        check_eq("t6_tie_winner", glog[start], 1'b0);
        wait_idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
